train_sequencer: RTL and testbench
==================================

# train_sequencer

Host-facing sequencer that sits between a host command port and the `data_path` block. It serializes host loads into the weight, input, label and code storages over one shared registered write bus. On request it then runs a training/inference pass: it resets the matrix locator, enables the controller and code storage for a programmed number of cycles, and reports completion.

## Interface
Parameters:
- `DATA_W`, default 48, fixed-point word width of storage data.
- `IDX_W`, default 32, layer/row/line index width and run-counter width.
- `CODE_W`, default 12, code storage word width.

Ports:
- `clk_clk` in 1: single clock, all logic on the rising edge.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_target` in 2: 0 = weight, 1 = input, 2 = label, 3 = code.
- `cmd_layer` in IDX_W: layer index; ignored for code.
- `cmd_row` in IDX_W: row index; for code, the code line.
- `cmd_data` in DATA_W: write data; for code, bits [CODE_W-1:0] are used.
- `start` in 1: level-sampled request to begin a run.
- `run_cycles` in IDX_W: controller-enable duration, sampled on start.
- `abort` in 1: terminate a run early.
- `use_z` in 1: from `controller_use_z`.
- `wr_layer_index` out IDX_W: shared bus to the weight, input and label storages.
- `wr_row_index` out IDX_W: same shared bus.
- `wr_data` out DATA_W: same shared bus.
- `weight_is_write`, `input_is_write`, `label_is_write`, `code_is_write` out 1 each: one-hot write strobes.
- `code_write_line` out IDX_W.
- `code_write_data` out CODE_W.
- `code_enable` out 1.
- `controller_enable` out 1.
- `locator_reset` out 1.
- `busy` out 1.
- `done` out 1: one-cycle pulse.
- `aborted` out 1: valid with `done`.
- `use_z_count` out IDX_W: cycles with `use_z` high during the last run.

## Operation
- FSM states: IDLE, LOC_RST, RUN, DRAIN, DONE.
- IDLE:
  - `cmd_ready = ~start`; start has priority over a same-cycle command.
  - An accepted command registers the bus fields and asserts exactly one strobe for one cycle.
  - Strobes are never asserted in any other state.
  - `start=1` → LOC_RST; `run_cycles` is latched into `remaining`; 0 is treated as 1.
- LOC_RST:
  - `locator_reset=1` for exactly one cycle.
  - `use_z_count` is cleared.
  - → RUN.
- RUN:
  - `controller_enable=1` and `code_enable=1`.
  - `remaining` decrements each cycle; `use_z_count` increments when `use_z=1`, saturating at all-ones.
  - `remaining==1` or `abort=1` → DRAIN.
  - `aborted` is latched when `abort` caused the exit.
- DRAIN: both enables are 0 for one cycle, allowing the datapath pipeline to settle → DONE.
- DONE: `done=1` for one cycle → IDLE.
- `busy=1` in LOC_RST, RUN, DRAIN and DONE.
- `abort` is ignored outside RUN; `start` is ignored outside IDLE.
- Code writes drive `code_write_line=cmd_row` and `code_write_data=cmd_data[CODE_W-1:0]`. The shared bus still updates but no weight, input or label strobe fires.
- `code_enable` is also held 1 during a code write (the storage needs enable to write); otherwise 0 in IDLE.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - `remaining` and `use_z_count` 0.
  - `cmd_ready` follows `~start` combinationally.
- Write latency: handshake in cycle N → strobe, bus and `code_enable` valid in cycle N+1 only; the bus holds its value afterwards.
- Back-to-back commands: one accepted per cycle, with no bubbles.
- Run of R cycles with start sampled at N:
  - `locator_reset` at N+1.
  - `controller_enable` over N+2..N+1+R.
  - DRAIN at N+2+R.
  - `done` at N+3+R.
  - `cmd_ready` high again at N+4+R.
- Abort sampled in RUN cycle M: the enable drops at M+1 and `done` fires at M+2.
- Reset asserted mid-run: all outputs drop asynchronously to 0 and the FSM returns to IDLE. No `done` is produced.

## Structure
- Shared package `train_seq_pkg` holds:
  - the target enum (WEIGHT, INPUT, LABEL, CODE);
  - the FSM state enum;
  - the default widths.
- Sub-module `run_counter`: the loadable down-counter with terminal flag, plus the saturating `use_z` counter. Everything else stays flat.

## Test plan
- Reset mid-RUN (R=100, reset at cycle 40) → all outputs 0 immediately, IDLE, no `done`. After release, a command is accepted the next cycle.
- Three back-to-back commands:
  - weight (L=1, R=2, D=0x000000001000), then input (L=0, R=5), then label (L=2, R=0);
  - → three consecutive cycles with exactly one strobe each and matching bus values.
- Code write: row=7, data=0xABCDEF123FFF → `code_is_write=1` with line=7, data=0xFFF and `code_enable=1` for one cycle; the other strobes stay 0.
- Run R=5, `use_z` high in 2 of the run cycles:
  - `locator_reset` 1 cycle, `controller_enable` exactly 5 cycles, `done` 2 cycles later;
  - `use_z_count=2`, `aborted=0`.
- `start` and `cmd_valid` asserted in the same cycle → `cmd_ready=0`, no strobe, run begins. A run with R=0 gives exactly 1 enable cycle.
- Abort in the third RUN cycle of R=50 → enable low the next cycle, `done` with `aborted=1` one cycle later. An abort applied in IDLE has no effect.

Source files
------------

// File: rtl/train_seq_pkg.sv
// Shared definitions for the training sequencer: default widths, the host
// command target encoding and the sequencer FSM state encoding.
package train_seq_pkg;

  localparam int unsigned DefaultDataW = 48;
  localparam int unsigned DefaultIdxW  = 32;
  localparam int unsigned DefaultCodeW = 12;

  // Host command destination, matches the encoding of cmd_target.
  typedef enum logic [1:0] {
    TgtWeight = 2'd0,
    TgtInput  = 2'd1,
    TgtLabel  = 2'd2,
    TgtCode   = 2'd3
  } target_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLocRst = 3'd1,
    StRun    = 3'd2,
    StDrain  = 3'd3,
    StDone   = 3'd4
  } state_e;

endpackage

// File: rtl/run_counter.sv
// Run-length and use_z bookkeeping for the training sequencer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : load load_value into the down-counter (0 loads as 1)
//   dec          : decrement the down-counter (stops at 0)
//   z_clear      : clear the use_z counter
//   z_inc        : increment the use_z counter, saturating at all-ones
//   last         : down-counter currently holds 1 (final run cycle)
//   z_count      : current use_z counter value
module run_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  input  logic         z_clear,
  input  logic         z_inc,
  output logic         last,
  output logic [W-1:0] z_count
);

  logic [W-1:0] remaining_q;
  logic [W-1:0] z_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
    end else if (load) begin
      // A zero-length request still gets one enable cycle.
      remaining_q <= (load_value == '0) ? W'(1) : load_value;
    end else if (dec && (remaining_q != '0)) begin
      remaining_q <= remaining_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_count_q <= '0;
    end else if (z_clear) begin
      z_count_q <= '0;
    end else if (z_inc && (z_count_q != '1)) begin
      z_count_q <= z_count_q + W'(1);
    end
  end

  assign last    = (remaining_q == W'(1));
  assign z_count = z_count_q;

endmodule

// File: rtl/train_sequencer.sv
// Host-facing sequencer in front of data_path. Serialises host loads into the
// weight/input/label/code storages over one registered write bus, and runs a
// training/inference pass of a programmed length on request.
//   clk_clk, reset_reset_n      : clock, asynchronous active-low reset
//   cmd_valid/ready/target/...  : host write command (accepted only in idle)
//   start, run_cycles, abort    : run control; use_z from the controller
//   wr_* and *_is_write         : shared storage write bus and one-hot strobes
//   code_write_line/data        : code storage write port
//   code_enable, controller_enable, locator_reset : datapath control
//   busy, done, aborted, use_z_count             : run status
module train_sequencer
  import train_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned IDX_W  = DefaultIdxW,
  parameter int unsigned CODE_W = DefaultCodeW
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_target,
  input  logic [IDX_W-1:0]  cmd_layer,
  input  logic [IDX_W-1:0]  cmd_row,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              start,
  input  logic [IDX_W-1:0]  run_cycles,
  input  logic              abort,
  input  logic              use_z,
  output logic [IDX_W-1:0]  wr_layer_index,
  output logic [IDX_W-1:0]  wr_row_index,
  output logic [DATA_W-1:0] wr_data,
  output logic              weight_is_write,
  output logic              input_is_write,
  output logic              label_is_write,
  output logic              code_is_write,
  output logic [IDX_W-1:0]  code_write_line,
  output logic [CODE_W-1:0] code_write_data,
  output logic              code_enable,
  output logic              controller_enable,
  output logic              locator_reset,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [IDX_W-1:0]  use_z_count
);

  state_e state_q;
  logic   cmd_accept;
  logic   run_last;

  // Start wins over a same-cycle command.
  assign cmd_ready  = (state_q == StIdle) && !start;
  assign cmd_accept = cmd_valid && cmd_ready;

  run_counter #(
    .W (IDX_W)
  ) u_run_counter (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .load       ((state_q == StIdle) && start),
    .load_value (run_cycles),
    .dec        (state_q == StRun),
    .z_clear    (state_q == StLocRst),
    .z_inc      ((state_q == StRun) && use_z),
    .last       (run_last),
    .z_count    (use_z_count)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q           <= StIdle;
      wr_layer_index    <= '0;
      wr_row_index      <= '0;
      wr_data           <= '0;
      weight_is_write   <= 1'b0;
      input_is_write    <= 1'b0;
      label_is_write    <= 1'b0;
      code_is_write     <= 1'b0;
      code_write_line   <= '0;
      code_write_data   <= '0;
      code_enable       <= 1'b0;
      controller_enable <= 1'b0;
      locator_reset     <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      aborted           <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      weight_is_write <= 1'b0;
      input_is_write  <= 1'b0;
      label_is_write  <= 1'b0;
      code_is_write   <= 1'b0;
      locator_reset   <= 1'b0;
      done            <= 1'b0;

      unique case (state_q)
        StIdle: begin
          code_enable <= 1'b0;
          if (start) begin
            state_q       <= StLocRst;
            busy          <= 1'b1;
            locator_reset <= 1'b1;
          end else if (cmd_accept) begin
            // The shared bus follows every command, including code writes.
            wr_layer_index <= cmd_layer;
            wr_row_index   <= cmd_row;
            wr_data        <= cmd_data;
            unique case (target_e'(cmd_target))
              TgtWeight: weight_is_write <= 1'b1;
              TgtInput:  input_is_write  <= 1'b1;
              TgtLabel:  label_is_write  <= 1'b1;
              TgtCode: begin
                code_is_write   <= 1'b1;
                code_enable     <= 1'b1;
                code_write_line <= cmd_row;
                code_write_data <= cmd_data[CODE_W-1:0];
              end
            endcase
          end
        end

        StLocRst: begin
          state_q           <= StRun;
          controller_enable <= 1'b1;
          code_enable       <= 1'b1;
          aborted           <= 1'b0;
        end

        StRun: begin
          if (run_last || abort) begin
            state_q           <= StDrain;
            controller_enable <= 1'b0;
            code_enable       <= 1'b0;
            aborted           <= abort;
          end
        end

        // Enables stay low for one cycle so the datapath pipeline settles.
        StDrain: begin
          state_q <= StDone;
          done    <= 1'b1;
        end

        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end

        default: begin
          state_q           <= StIdle;
          busy              <= 1'b0;
          controller_enable <= 1'b0;
          code_enable       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_train_sequencer.sv
module tb_train_sequencer;

  logic        clk_clk;
  logic        reset_reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_target;
  logic [31:0] cmd_layer;
  logic [31:0] cmd_row;
  logic [47:0] cmd_data;
  logic        start;
  logic [31:0] run_cycles;
  logic        abort;
  logic        use_z;
  logic [31:0] wr_layer_index;
  logic [31:0] wr_row_index;
  logic [47:0] wr_data;
  logic        weight_is_write;
  logic        input_is_write;
  logic        label_is_write;
  logic        code_is_write;
  logic [31:0] code_write_line;
  logic [11:0] code_write_data;
  logic        code_enable;
  logic        controller_enable;
  logic        locator_reset;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] use_z_count;

  int n_checks = 0;
  int n_fail   = 0;

  train_sequencer dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_target        (cmd_target),
    .cmd_layer         (cmd_layer),
    .cmd_row           (cmd_row),
    .cmd_data          (cmd_data),
    .start             (start),
    .run_cycles        (run_cycles),
    .abort             (abort),
    .use_z             (use_z),
    .wr_layer_index    (wr_layer_index),
    .wr_row_index      (wr_row_index),
    .wr_data           (wr_data),
    .weight_is_write   (weight_is_write),
    .input_is_write    (input_is_write),
    .label_is_write    (label_is_write),
    .code_is_write     (code_is_write),
    .code_write_line   (code_write_line),
    .code_write_data   (code_write_data),
    .code_enable       (code_enable),
    .controller_enable (controller_enable),
    .locator_reset     (locator_reset),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted),
    .use_z_count       (use_z_count)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {code_is_write, label_is_write, input_is_write, weight_is_write};
  endfunction

  task automatic idle_inputs();
    cmd_valid  = 1'b0;
    cmd_target = 2'd0;
    cmd_layer  = '0;
    cmd_row    = '0;
    cmd_data   = '0;
    start      = 1'b0;
    run_cycles = '0;
    abort      = 1'b0;
    use_z      = 1'b0;
  endtask

  // Run reference: a run of R cycles enables for max(R,1) cycles unless an
  // abort arrives in run cycle A first, giving A cycles; done follows two
  // cycles after the last enable cycle and the sequencer is idle one later.
  task automatic do_run(input int r, input int abort_at, input logic [63:0] zmask,
                        input bit with_cmd, input string tag);
    int eff, e, zc, en_cnt, ce_cnt, lr_cnt, done_cnt, done_at;
    bit exp_abort;
    eff       = (r == 0) ? 1 : r;
    exp_abort = (abort_at >= 1) && (abort_at <= eff);
    e         = exp_abort ? abort_at : eff;
    zc = 0; en_cnt = 0; ce_cnt = 0; done_cnt = 0; done_at = 0;
    start      = 1'b1;
    run_cycles = 32'(r);
    if (with_cmd) begin
      cmd_valid  = 1'b1;
      cmd_target = 2'd0;
      #1;
      check({tag, " cmd_ready with start"}, 64'(cmd_ready), 64'd0);
    end
    step();
    start     = 1'b0;
    cmd_valid = 1'b0;
    if (with_cmd) check({tag, " no strobe on start"}, 64'(strobes()), 64'd0);
    lr_cnt = int'(locator_reset);
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    // Abort and use_z must both be ignored during the locator reset cycle.
    abort = 1'b1;
    use_z = 1'b1;
    step();
    for (int k = 1; k <= e + 3; k++) begin
      if (k == 1) check({tag, " use_z_count cleared"}, 64'(use_z_count), 64'd0);
      en_cnt += int'(controller_enable);
      ce_cnt += int'(code_enable);
      lr_cnt += int'(locator_reset);
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        check({tag, " aborted at done"}, 64'(aborted), 64'(exp_abort));
        check({tag, " use_z_count at done"}, 64'(use_z_count), 64'(zc));
      end
      if (k == e + 3) begin
        check({tag, " busy back low"}, 64'(busy), 64'd0);
        check({tag, " cmd_ready back high"}, 64'(cmd_ready), 64'd1);
      end
      if (k <= e) begin
        use_z = zmask[k-1];
        zc   += int'(zmask[k-1]);
        abort = (k == abort_at);
      end else begin
        use_z = 1'b1;
        abort = 1'b0;
      end
      step();
    end
    use_z = 1'b0;
    abort = 1'b0;
    check({tag, " locator_reset cycles"}, 64'(lr_cnt), 64'd1);
    check({tag, " controller_enable cycles"}, 64'(en_cnt), 64'(e));
    check({tag, " code_enable cycles"}, 64'(ce_cnt), 64'(e));
    check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " done position"}, 64'(done_at), 64'(e + 2));
  endtask

  typedef struct {
    logic [1:0]  tgt;
    logic [31:0] layer;
    logic [31:0] row;
    logic [47:0] data;
    logic [3:0]  exp_strobe;  // {code, label, input, weight}
    logic [31:0] exp_cline;
    logic [11:0] exp_cdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [3:0]  m_strobe;
    logic [31:0] m_layer, m_row, m_cline;
    logic [47:0] m_data;
    logic [11:0] m_cdata;
    int          dcnt;

    vecs[0] = '{2'd0, 32'd1, 32'd2, 48'h000000001000, 4'b0001, 32'd0, 12'h000};
    vecs[1] = '{2'd1, 32'd0, 32'd5, 48'h00000000abcd, 4'b0010, 32'd0, 12'h000};
    vecs[2] = '{2'd2, 32'd2, 32'd0, 48'h123456789abc, 4'b0100, 32'd0, 12'h000};
    vecs[3] = '{2'd3, 32'd9, 32'd7, 48'habcdef123fff, 4'b1000, 32'd7, 12'hfff};

    idle_inputs();
    reset_reset_n = 1'b0;
    #3;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset enables", 64'({controller_enable, code_enable, locator_reset}), 64'd0);
    check("reset strobes", 64'(strobes()), 64'd0);
    check("reset bus", 64'(wr_layer_index | wr_row_index) | 64'(wr_data), 64'd0);
    check("reset use_z_count", 64'(use_z_count), 64'd0);
    check("reset cmd_ready", 64'(cmd_ready), 64'd1);
    start = 1'b1;
    #1;
    check("cmd_ready follows start", 64'(cmd_ready), 64'd0);
    start = 1'b0;
    #4;
    reset_reset_n = 1'b1;
    step();

    // Back-to-back commands from the vector table, one per cycle.
    for (int i = 0; i < 4; i++) begin
      cmd_valid  = 1'b1;
      cmd_target = vecs[i].tgt;
      cmd_layer  = vecs[i].layer;
      cmd_row    = vecs[i].row;
      cmd_data   = vecs[i].data;
      #1;
      check($sformatf("vec%0d cmd_ready", i), 64'(cmd_ready), 64'd1);
      step();
      check($sformatf("vec%0d strobes", i), 64'(strobes()), 64'(vecs[i].exp_strobe));
      check($sformatf("vec%0d layer", i), 64'(wr_layer_index), 64'(vecs[i].layer));
      check($sformatf("vec%0d row", i), 64'(wr_row_index), 64'(vecs[i].row));
      check($sformatf("vec%0d data", i), 64'(wr_data), 64'(vecs[i].data));
      check($sformatf("vec%0d code_line", i), 64'(code_write_line), 64'(vecs[i].exp_cline));
      check($sformatf("vec%0d code_data", i), 64'(code_write_data), 64'(vecs[i].exp_cdata));
      check($sformatf("vec%0d code_enable", i), 64'(code_enable), 64'(vecs[i].exp_strobe[3]));
    end
    cmd_valid = 1'b0;
    step();
    check("after cmds strobes", 64'(strobes()), 64'd0);
    check("after cmds code_enable", 64'(code_enable), 64'd0);
    check("bus holds layer", 64'(wr_layer_index), 64'd9);
    check("bus holds data", 64'(wr_data), 64'habcdef123fff);

    // Abort in idle does nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle abort busy", 64'(busy), 64'd0);
    check("idle abort done", 64'(done | aborted), 64'd0);

    do_run(5, 0, 64'b01010, 1'b0, "R5");
    do_run(0, 0, 64'h1, 1'b1, "R0+cmd");
    do_run(50, 3, 64'b111, 1'b0, "R50 abort3");
    do_run(1, 1, 64'h0, 1'b0, "R1 abort1");

    for (int i = 0; i < 6; i++) begin
      int r, ab;
      r  = int'($urandom_range(0, 12));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (r == 0) ? 1 : r)) : 0;
      do_run(r, ab, {$urandom, $urandom}, 1'b0, $sformatf("rand run %0d", i));
    end

    // Random command stream against a bus model.
    m_layer = wr_layer_index;
    m_row   = wr_row_index;
    m_data  = wr_data;
    m_cline = 32'd7;
    m_cdata = 12'hfff;
    for (int i = 0; i < 30; i++) begin
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_target = 2'($urandom_range(0, 3));
      cmd_layer  = $urandom;
      cmd_row    = $urandom;
      cmd_data   = {16'($urandom), $urandom};
      m_strobe   = 4'd0;
      if (cmd_valid) begin
        m_strobe = 4'd1 << cmd_target;
        m_layer  = cmd_layer;
        m_row    = cmd_row;
        m_data   = cmd_data;
        if (cmd_target == 2'd3) begin
          m_cline = cmd_row;
          m_cdata = 12'(cmd_data % 4096);
        end
      end
      step();
      check($sformatf("rand cmd %0d strobes", i), 64'(strobes()), 64'(m_strobe));
      check($sformatf("rand cmd %0d bus", i), {wr_layer_index, wr_row_index} ^ 64'(wr_data),
            {m_layer, m_row} ^ 64'(m_data));
      check($sformatf("rand cmd %0d code", i), {code_write_line, 20'(code_write_data)},
            {m_cline, 20'(m_cdata)});
      check($sformatf("rand cmd %0d code_enable", i), 64'(code_enable), 64'(m_strobe[3]));
    end
    cmd_valid = 1'b0;
    step();

    // Reset in the middle of a long run.
    start      = 1'b1;
    run_cycles = 32'd100;
    step();
    start = 1'b0;
    use_z = 1'b1;
    repeat (39) step();
    check("midrun enable before reset", 64'(controller_enable), 64'd1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("midrun reset busy", 64'(busy), 64'd0);
    check("midrun reset enables", 64'({controller_enable, code_enable, locator_reset}), 64'd0);
    check("midrun reset done", 64'(done | aborted), 64'd0);
    check("midrun reset use_z_count", 64'(use_z_count), 64'd0);
    check("midrun reset cmd_ready", 64'(cmd_ready), 64'd1);
    #2;
    reset_reset_n = 1'b1;
    use_z         = 1'b0;
    cmd_valid     = 1'b1;
    cmd_target    = 2'd2;
    cmd_layer     = 32'd3;
    step();
    cmd_valid = 1'b0;
    check("post reset label strobe", 64'(strobes()), 64'b0100);
    check("post reset layer", 64'(wr_layer_index), 64'd3);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      dcnt += int'(done) + int'(busy);
      step();
    end
    check("post reset no done", 64'(dcnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
